// File: rtl/edf_irq_stamper.sv
// -----------------------------------------------------------------------------
// edf_irq_stamper
//
// Front-end of the EDF interrupt controller. Detects rising edges on the
// parallel interrupt lines, stamps each event with an absolute deadline
// (mtime + per-line relative deadline) and offers pending events one at a time
// to the downstream deadline-ordered priority queue.
//
// Ports
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   cfg_req_i      config write strobe (write-only bus)
//   cfg_addr_i     config byte address (bits [1:0] ignored)
//   cfg_wdata_i    config write data
//   mtime_i        platform timer value
//   irq_i          level interrupt lines, rising edge = event
//   stamp_id_o     ID of the offered event
//   stamp_dl_o     absolute deadline of the offered event
//   stamp_valid_o  event offered to the priority queue
//   stamp_ready_i  priority queue accepts the event
//   overrun_o      sticky per-line flag: edge dropped while line still pending
//   dbg_state_o    FSM state for observation (0 = IDLE, 1 = OFFER)
//
// Config map (word aligned):
//   0x000 + 4*i  relative deadline of line i
//   0x100        line enable mask
//   0x104        overrun flags, write 1 to clear
//
// Handshake: stamp_valid_o/stamp_ready_i follow strict valid/ready rules. Once
// stamp_valid_o rises, stamp_id_o and stamp_dl_o stay stable and valid stays
// high until a cycle with stamp_ready_i=1 (only reset can abort the offer).
// The transfer happens on a clock edge where both are high; ready while valid
// is low has no effect.
// -----------------------------------------------------------------------------
module edf_irq_stamper #(
   parameter  int NrParIrqs = 4,
   parameter  int DlWidth   = 32,
   localparam int IdWidth   = (NrParIrqs > 1) ? $clog2(NrParIrqs) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cfg_req_i,
   input  logic [31:0]          cfg_addr_i,
   input  logic [31:0]          cfg_wdata_i,
   input  logic [63:0]          mtime_i,
   input  logic [NrParIrqs-1:0] irq_i,
   output logic [IdWidth-1:0]   stamp_id_o,
   output logic [63:0]          stamp_dl_o,
   output logic                 stamp_valid_o,
   input  logic                 stamp_ready_i,
   output logic [NrParIrqs-1:0] overrun_o,
   output logic                 dbg_state_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_e;

   state_e               state_q, state_d;

   logic [NrParIrqs-1:0] irq_q;
   logic [NrParIrqs-1:0] pending_q;
   logic [NrParIrqs-1:0] enable_q;
   logic [NrParIrqs-1:0] overrun_q;
   logic [DlWidth-1:0]   reldl_q [NrParIrqs];
   logic [63:0]          absdl_q [NrParIrqs];
   logic [IdWidth-1:0]   ptr_q, ptr_d;

   logic [NrParIrqs-1:0] rise;
   logic [NrParIrqs-1:0] accept_vec;
   logic                 accept;

   logic [NrParIrqs-1:0] reldl_we;
   logic                 enable_we;
   logic                 w1c_we;

   logic                 sel_found;
   logic [IdWidth-1:0]   sel_id;

   logic [IdWidth-1:0]   id_d;
   logic [63:0]          dl_d;
   logic                 valid_d;

   // ---------------------------------------------------------------------------
   // Config decode (word address, byte lanes ignored)
   // ---------------------------------------------------------------------------
   always_comb begin
      reldl_we = '0;
      for (int i = 0; i < NrParIrqs; i++) begin
         reldl_we[i] = cfg_req_i && (cfg_addr_i[31:2] == 30'(i));
      end
   end

   assign enable_we = cfg_req_i && (cfg_addr_i[31:2] == 30'h40);
   assign w1c_we    = cfg_req_i && (cfg_addr_i[31:2] == 30'h41);

   // ---------------------------------------------------------------------------
   // Edge detect and acceptance
   // ---------------------------------------------------------------------------
   assign rise   = irq_i & ~irq_q & enable_q;
   assign accept = (state_q == OFFER) && stamp_ready_i;

   always_comb begin
      accept_vec = '0;
      if (accept) begin
         accept_vec[stamp_id_o] = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Per-line state. A rise on the line being accepted this cycle re-arms it
   // (set wins over clear) and re-stamps the deadline; the accepted event keeps
   // the deadline already latched in stamp_dl_o.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         irq_q     <= '0;
         pending_q <= '0;
         enable_q  <= '0;
         overrun_q <= '0;
         for (int i = 0; i < NrParIrqs; i++) begin
            reldl_q[i] <= '0;
            absdl_q[i] <= '0;
         end
      end else begin
         irq_q <= irq_i;

         if (enable_we) begin
            enable_q <= cfg_wdata_i[NrParIrqs-1:0];
         end

         for (int i = 0; i < NrParIrqs; i++) begin
            if (reldl_we[i]) begin
               reldl_q[i] <= DlWidth'(cfg_wdata_i);
            end

            // absdl uses the reldl value present before any same-cycle write.
            if (rise[i] && (!pending_q[i] || accept_vec[i])) begin
               pending_q[i] <= 1'b1;
               absdl_q[i]   <= mtime_i + 64'(reldl_q[i]);
            end else if (accept_vec[i]) begin
               pending_q[i] <= 1'b0;
            end
         end

         // Clear first, then OR in new drops so a same-cycle set wins.
         overrun_q <= (w1c_we ? (overrun_q & ~cfg_wdata_i[NrParIrqs-1:0]) : overrun_q)
                    | (rise & pending_q & ~accept_vec);
      end
   end

   // ---------------------------------------------------------------------------
   // Round-robin pick: first pending line at or above ptr, wrapping.
   // ---------------------------------------------------------------------------
   always_comb begin
      sel_found = 1'b0;
      sel_id    = '0;
      for (int k = 0; k < NrParIrqs; k++) begin
         if (!sel_found && pending_q[(int'(ptr_q) + k) % NrParIrqs]) begin
            sel_found = 1'b1;
            sel_id    = IdWidth'((int'(ptr_q) + k) % NrParIrqs);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Offer FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      id_d    = stamp_id_o;
      dl_d    = stamp_dl_o;
      valid_d = stamp_valid_o;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (sel_found) begin
               id_d    = sel_id;
               dl_d    = absdl_q[sel_id];
               valid_d = 1'b1;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (stamp_ready_i) begin
               valid_d = 1'b0;
               state_d = IDLE;
               ptr_d   = (stamp_id_o == IdWidth'(NrParIrqs - 1)) ? '0
                                                                 : stamp_id_o + IdWidth'(1);
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         stamp_id_o    <= '0;
         stamp_dl_o    <= '0;
         stamp_valid_o <= 1'b0;
         ptr_q         <= '0;
      end else begin
         state_q       <= state_d;
         stamp_id_o    <= id_d;
         stamp_dl_o    <= dl_d;
         stamp_valid_o <= valid_d;
         ptr_q         <= ptr_d;
      end
   end

   assign overrun_o   = overrun_q;
   assign dbg_state_o = (state_q == OFFER);

endmodule

// File: tb/tb_edf_irq_stamper.sv
// -----------------------------------------------------------------------------
// Bench for edf_irq_stamper: directed scenarios followed by a randomized run,
// every cycle compared against an event-level reference model.
// -----------------------------------------------------------------------------
module tb_edf_irq_stamper;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_req;
   logic [31:0] cfg_addr;
   logic [31:0] cfg_wdata;
   logic [63:0] mtime;
   logic [3:0]  irq;
   logic [1:0]  stamp_id;
   logic [63:0] stamp_dl;
   logic        stamp_valid;
   logic        stamp_ready;
   logic [3:0]  overrun;
   logic        dbg_state;

   always #5 clk = ~clk;

   edf_irq_stamper #(.NrParIrqs(4), .DlWidth(32)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .cfg_req_i     (cfg_req),
      .cfg_addr_i    (cfg_addr),
      .cfg_wdata_i   (cfg_wdata),
      .mtime_i       (mtime),
      .irq_i         (irq),
      .stamp_id_o    (stamp_id),
      .stamp_dl_o    (stamp_dl),
      .stamp_valid_o (stamp_valid),
      .stamp_ready_i (stamp_ready),
      .overrun_o     (overrun),
      .dbg_state_o   (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Counters, handshake log
   // ---------------------------------------------------------------------------
   int n_vec = 0;
   int n_err = 0;
   int acc_log[$];

   // ---------------------------------------------------------------------------
   // Reference model: a set of pending lines each holding a deadline, one offer
   // slot, and a round-robin start position.
   // ---------------------------------------------------------------------------
   logic [3:0]  m_irq_q;
   logic [3:0]  m_en;
   logic [3:0]  m_pend;
   logic [3:0]  m_ovr;
   logic [31:0] m_reldl [4];
   logic [63:0] m_abs   [4];
   int          m_ptr;
   bit          m_valid;
   int          m_id;
   logic [63:0] m_dl;

   task automatic model_reset();
      m_irq_q = '0; m_en = '0; m_pend = '0; m_ovr = '0;
      for (int i = 0; i < 4; i++) begin
         m_reldl[i] = '0;
         m_abs[i]   = '0;
      end
      m_ptr = 0; m_valid = 0; m_id = 0; m_dl = '0;
   endtask

   // Called at each rising edge, with the inputs that were present before it.
   task automatic model_step();
      logic [3:0]  n_pend;
      logic [3:0]  n_ovr;
      logic [63:0] n_abs [4];
      bit          acc;
      bit          found;
      bit          r;
      if (!rst_n) begin
         model_reset();
         return;
      end
      acc    = m_valid && stamp_ready;
      n_pend = m_pend;
      n_ovr  = m_ovr;
      n_abs  = m_abs;
      if (cfg_req && ((cfg_addr & ~32'h3) == 32'h104)) n_ovr = n_ovr & ~cfg_wdata[3:0];
      for (int i = 0; i < 4; i++) begin
         r = irq[i] && !m_irq_q[i] && m_en[i];
         if (r && (!m_pend[i] || (acc && m_id == i))) begin
            n_pend[i] = 1'b1;
            n_abs[i]  = mtime + {32'h0, m_reldl[i]};
         end else if (r) begin
            n_ovr[i] = 1'b1;
         end else if (acc && m_id == i) begin
            n_pend[i] = 1'b0;
         end
      end
      // Offer slot works on the state before this edge.
      if (m_valid) begin
         if (stamp_ready) begin
            m_valid = 0;
            m_ptr   = (m_id + 1) % 4;
         end
      end else begin
         found = 0;
         for (int k = 0; k < 4; k++) begin
            if (!found && m_pend[(m_ptr + k) % 4]) begin
               found   = 1;
               m_valid = 1;
               m_id    = (m_ptr + k) % 4;
               m_dl    = m_abs[m_id];
            end
         end
      end
      m_pend = n_pend;
      m_ovr  = n_ovr;
      m_abs  = n_abs;
      if (cfg_req) begin
         for (int i = 0; i < 4; i++) begin
            if ((cfg_addr & ~32'h3) == 32'(4 * i)) m_reldl[i] = cfg_wdata;
         end
         if ((cfg_addr & ~32'h3) == 32'h100) m_en = cfg_wdata[3:0];
      end
      m_irq_q = irq;
   endtask

   // ---------------------------------------------------------------------------
   // Check / drive helpers
   // ---------------------------------------------------------------------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("valid", 64'(stamp_valid), 64'(m_valid));
      if (m_valid) begin
         chk("id", 64'(stamp_id), 64'(m_id));
         chk("dl", stamp_dl, m_dl);
      end
      chk("overrun", 64'(overrun), 64'(m_ovr));
   endtask

   task automatic tick();
      if (rst_n && stamp_valid && stamp_ready) acc_log.push_back(int'(stamp_id));
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
   endtask

   task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
      cfg_req   = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      tick();
      cfg_req   = 1'b0;
      cfg_addr  = '0;
      cfg_wdata = '0;
   endtask

   task automatic chk_order(input string tag, input int exp_ids[$]);
      chk({tag, "_len"}, 64'(acc_log.size()), 64'(exp_ids.size()));
      for (int i = 0; i < exp_ids.size(); i++) begin
         chk(tag, 64'((i < acc_log.size()) ? acc_log[i] : -1), 64'(exp_ids[i]));
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int sel;
      rst_n = 1'b0; cfg_req = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      mtime = '0; irq = '0; stamp_ready = 1'b0;
      model_reset();

      // Reset state
      tick(); tick();
      chk("rst_valid", 64'(stamp_valid), 64'd0);
      chk("rst_id", 64'(stamp_id), 64'd0);
      chk("rst_dl", stamp_dl, 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      rst_n = 1'b1;

      // Basic stamp, latency and hold under backpressure
      cfg_write(32'h008, 32'd100);
      cfg_write(32'h100, 32'hF);
      mtime = 64'd1000;
      irq   = 4'b0100;
      tick();
      chk("lat_t1_valid", 64'(stamp_valid), 64'd0);
      tick();
      chk("lat_t2_valid", 64'(stamp_valid), 64'd1);
      chk("basic_id", 64'(stamp_id), 64'd2);
      chk("basic_dl", stamp_dl, 64'd1100);
      repeat (5) begin
         tick();
         chk("hold_id", 64'(stamp_id), 64'd2);
         chk("hold_dl", stamp_dl, 64'd1100);
      end
      stamp_ready = 1'b1;
      tick();
      chk("drop_valid", 64'(stamp_valid), 64'd0);
      stamp_ready = 1'b0;

      // Deadline wrap
      irq = 4'b0000;
      cfg_write(32'h004, 32'h10);
      mtime = 64'hFFFF_FFFF_FFFF_FFF8;
      irq   = 4'b0010;
      tick(); tick();
      chk("wrap_id", 64'(stamp_id), 64'd1);
      chk("wrap_dl", stamp_dl, 64'h8);
      stamp_ready = 1'b1;
      tick();
      stamp_ready = 1'b0;
      irq = 4'b0000;
      tick();

      // Move the round-robin pointer to 0 by delivering line 3
      irq = 4'b1000;
      tick(); tick();
      stamp_ready = 1'b1;
      tick();
      irq = 4'b0000;
      tick();

      // All four lines at once, twice, then 3 and 1 with the pointer at 2
      acc_log.delete();
      irq = 4'b1111;
      tick();
      irq = 4'b0000;
      repeat (11) tick();
      chk_order("rr_a", '{0, 1, 2, 3});
      acc_log.delete();
      irq = 4'b1111;
      tick();
      irq = 4'b0000;
      repeat (11) tick();
      chk_order("rr_b", '{0, 1, 2, 3});
      irq = 4'b0010;
      tick();
      irq = 4'b0000;
      repeat (5) tick();
      acc_log.delete();
      irq = 4'b1010;
      tick();
      irq = 4'b0000;
      repeat (7) tick();
      chk_order("rr_c", '{3, 1});

      // Overrun on line 0 under backpressure, then W1C
      stamp_ready = 1'b0;
      irq = 4'b0001; tick();
      irq = 4'b0000; tick();
      irq = 4'b0001; tick();
      tick();
      chk("ovr_set", 64'(overrun), 64'h1);
      chk("ovr_offer_id", 64'(stamp_id), 64'd0);
      stamp_ready = 1'b1;
      tick();
      stamp_ready = 1'b0;
      repeat (3) tick();
      chk("ovr_single_event", 64'(stamp_valid), 64'd0);
      cfg_write(32'h104, 32'h1);
      chk("ovr_w1c", 64'(overrun), 64'h0);

      // Masked line, then enable with line already high
      cfg_write(32'h100, 32'h0);
      irq = 4'b1001;
      repeat (10) begin
         tick();
         chk("masked_valid", 64'(stamp_valid), 64'd0);
      end
      cfg_write(32'h100, 32'h8);
      repeat (4) begin
         tick();
         chk("late_en_valid", 64'(stamp_valid), 64'd0);
      end
      irq = 4'b0000;
      tick();

      // Reset during OFFER
      cfg_write(32'h100, 32'hF);
      cfg_write(32'h008, 32'd5);
      mtime = 64'd2000;
      irq = 4'b0100; tick();
      irq = 4'b0000; tick();
      irq = 4'b0100; tick();
      tick();
      chk("pre_rst_valid", 64'(stamp_valid), 64'd1);
      chk("pre_rst_ovr", 64'(overrun), 64'h4);
      rst_n = 1'b0;
      stamp_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      stamp_ready = 1'b0;
      chk("mid_rst_valid", 64'(stamp_valid), 64'd0);
      chk("mid_rst_ovr", 64'(overrun), 64'h0);
      cfg_write(32'h100, 32'hF);
      irq = 4'b0000; tick();
      mtime = 64'd3000;
      irq = 4'b0100;
      tick(); tick();
      chk("fresh_valid", 64'(stamp_valid), 64'd1);
      chk("fresh_id", 64'(stamp_id), 64'd2);
      chk("fresh_dl", stamp_dl, 64'd3000);
      chk("fresh_ovr", 64'(overrun), 64'h0);
      stamp_ready = 1'b1;
      tick();
      stamp_ready = 1'b0;
      irq = 4'b0000;
      tick();

      // Randomized traffic
      for (int i = 0; i < 4; i++) cfg_write(32'(4 * i), $urandom_range(0, 5000));
      cfg_write(32'h100, 32'hF);
      for (int c = 0; c < 1500; c++) begin
         rst_n       = ($urandom_range(0, 199) != 0);
         irq         = irq ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
         stamp_ready = ($urandom_range(0, 2) != 0);
         mtime       = {$urandom, $urandom};
         cfg_req     = ($urandom_range(0, 7) == 0);
         cfg_wdata   = $urandom;
         sel         = $urandom_range(0, 7);
         case (sel)
            0, 1, 2, 3: cfg_addr = 32'(4 * sel) | 32'($urandom_range(0, 3));
            4:          begin cfg_addr = 32'h100; cfg_wdata = 32'($urandom_range(6, 15)); end
            5:          cfg_addr = 32'h104 | 32'($urandom_range(0, 3));
            6:          cfg_addr = 32'h010;
            default:    cfg_addr = 32'h200;
         endcase
         tick();
      end
      rst_n = 1'b1;
      cfg_req = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
